cond_resolve_stage: RTL and testbench
=====================================

Name: cond_resolve_stage

Overview:
- Registered, parametrised successor to the pipeline's combinational condition checker. Sits at the EX/MEM boundary of the pipelined MIPS core.
- Compares two operands internally (signed and unsigned), qualifies branch, register-write and memory-write requests, and raises an overflow trap.
- Adds a valid/ready pipeline handshake, a flush pulse, a trap-acknowledge state machine and saturating branch statistics counters.

Parameters:
DATA_W, 32, operand width in bits (>=2)
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX-stage request valid
in_ready  out  1  stage can accept a request this cycle
op_a  in  DATA_W  first compare operand
op_b  in  DATA_W  second compare operand
cond  in  4  condition code (see Behaviour)
branch  in  1  instruction is a branch
reg_write  in  1  instruction requests register write
mem_write  in  1  instruction requests memory write
alu_ovf  in  1  ALU arithmetic overflow flag
ovf_trap_en  in  1  instruction traps on overflow
out_valid  out  1  registered result valid
out_ready  in  1  MEM stage accepts result
branch_taken  out  1  qualified branch
reg_write_ok  out  1  qualified register write
mem_write_ok  out  1  qualified memory write
flush  out  1  one-cycle front-end flush pulse
trap  out  1  overflow trap pending
trap_ack  in  1  exception handler acknowledge
cnt_clr  in  1  synchronous clear of both counters
taken_cnt  out  CNT_W  taken-branch count
not_taken_cnt  out  CNT_W  not-taken-branch count

Behaviour:
- Condition code (cond true/false):
  - 0: none (true)
  - 1: eq
  - 2: ne
  - 3: gt
  - 4: ge
  - 5: lt
  - 6: le
  - 7: always (true)
  - 8: gtu
  - 9: geu
  - 10: ltu
  - 11: leu
  - 12: never (false)
  - 13–15: reserved, evaluate false
- Compare:
  - zero = (op_a == op_b).
  - Signed less uses the DATA_W+1-bit sign-extended difference; unsigned less uses the DATA_W+1-bit zero-extended borrow.
  - No dependence on the ALU.
- Qualification:
  - trap_hit = alu_ovf & ovf_trap_en.
  - If trap_hit: branch_taken, reg_write_ok and mem_write_ok are all 0.
  - Otherwise each output = request & cond_true.
- Handshake:
  - in_ready = (state==RUN) & (~out_valid | out_ready).
  - A transfer occurs when in_valid & in_ready. The result is registered, giving 1-cycle latency; out_valid is set on the next edge.
  - out_valid clears on out_ready when no new transfer occurs.
  - Output data holds stable while out_valid & ~out_ready.
- flush:
  - High for exactly one cycle, coincident with the first cycle of out_valid, when the registered result has branch_taken=1 or is a trap.
  - Not re-asserted while that result stalls.
- FSM:
  - RUN: normal operation. An accepted trap_hit moves to TRAP on the same edge that registers the result.
  - TRAP: trap=1 and in_ready=0. When trap_ack=1, return to RUN on the next edge. trap_ack in RUN is ignored.
  - A trap result is still presented on out_valid with all qualified outputs 0.
- Counters:
  - On each accepted request with branch=1 and no trap_hit, increment taken_cnt if the branch is taken, otherwise not_taken_cnt.
  - Both counters saturate at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle.
  - Trapping branches are not counted.
- Reset:
  - Asynchronous, any time including mid-transfer or mid-TRAP.
  - Afterwards: state=RUN; out_valid, branch_taken, reg_write_ok, mem_write_ok, flush and trap = 0; both counters = 0.
  - in_ready=1 in the first cycle after reset deassertion.

Test Plan:
1. DATA_W=8, op_a=8'hF0, op_b=8'h10: cond=5 (lt) -> taken; cond=10 (ltu) -> not taken. With branch=1, each result appears 1 cycle after acceptance with a single flush pulse for the taken case.
2. cond=1, op_a=op_b=5, reg_write=1 mem_write=1 -> reg_write_ok=1 and mem_write_ok=1. Repeat with cond=13 -> both outputs 0.
3. branch=1 cond=7, alu_ovf=1 ovf_trap_en=1 -> out_valid=1 with all outputs 0, flush=1 for 1 cycle, trap=1, in_ready=0 for 5 cycles until trap_ack, then in_ready=1 the cycle after. Counters unchanged.
4. out_ready=0 for 3 cycles with a taken result held -> outputs stable, flush only in the first cycle, in_ready=0. Back-to-back transfers with out_ready=1 sustain 1 result per cycle.
5. CNT_W=2: 5 taken branches -> taken_cnt saturates at 3. cnt_clr asserted together with a taken branch -> taken_cnt=0.
6. Assert rst_n=0 during TRAP with out_valid=1 -> all outputs 0 immediately (asynchronously), state RUN after release.

Source files
------------

// File: rtl/cond_resolve_stage.sv
// cond_resolve_stage: registered EX/MEM condition resolver. Evaluates a
// signed/unsigned compare of two operands, qualifies branch/register-write/
// memory-write requests, raises an overflow trap held until acknowledged,
// and keeps saturating taken/not-taken branch counters.
module cond_resolve_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [3:0]        cond,
   input  logic              branch,
   input  logic              reg_write,
   input  logic              mem_write,
   input  logic              alu_ovf,
   input  logic              ovf_trap_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              branch_taken,
   output logic              reg_write_ok,
   output logic              mem_write_ok,
   output logic              flush,
   output logic              trap,
   input  logic              trap_ack,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  not_taken_cnt
);

   typedef enum logic [0:0] {RUN = 1'b0, TRAP = 1'b1} state_t;

   state_t state_q, state_d;

   logic              out_valid_q, out_valid_d;
   logic              branch_taken_q, branch_taken_d;
   logic              reg_write_ok_q, reg_write_ok_d;
   logic              mem_write_ok_q, mem_write_ok_d;
   logic              flush_q, flush_d;
   logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0]  not_taken_cnt_q, not_taken_cnt_d;

   logic signed [DATA_W:0] sdiff;
   logic        [DATA_W:0] udiff;
   logic                   zero, slt, ult;
   logic                   cond_true;
   logic                   trap_hit;
   logic                   xfer;

   // Saturating increment: a counter at all-ones stays there.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // One extra bit keeps the sign of the difference exact for both compares.
   assign sdiff = $signed({op_a[DATA_W-1], op_a}) - $signed({op_b[DATA_W-1], op_b});
   assign udiff = {1'b0, op_a} - {1'b0, op_b};
   assign zero  = (op_a == op_b);
   assign slt   = sdiff[DATA_W];
   assign ult   = udiff[DATA_W];

   assign trap_hit = alu_ovf & ovf_trap_en;
   assign in_ready = (state_q == RUN) & (~out_valid_q | out_ready);
   assign xfer     = in_valid & in_ready;

   // Condition-code decode; reserved codes evaluate false.
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         4'd0:    cond_true = 1'b1;
         4'd1:    cond_true = zero;
         4'd2:    cond_true = ~zero;
         4'd3:    cond_true = ~slt & ~zero;
         4'd4:    cond_true = ~slt;
         4'd5:    cond_true = slt;
         4'd6:    cond_true = slt | zero;
         4'd7:    cond_true = 1'b1;
         4'd8:    cond_true = ~ult & ~zero;
         4'd9:    cond_true = ~ult;
         4'd10:   cond_true = ult;
         4'd11:   cond_true = ult | zero;
         default: cond_true = 1'b0;
      endcase
   end

   // Trap FSM next state: enter on an accepted trapping request, leave on ack.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (xfer && trap_hit) state_d = TRAP;
         TRAP:    if (trap_ack) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Result register next state: load on transfer, drain on out_ready, else hold.
   // flush is only set on the load edge so a stalled result never re-pulses it.
   always_comb begin
      out_valid_d    = out_valid_q;
      branch_taken_d = branch_taken_q;
      reg_write_ok_d = reg_write_ok_q;
      mem_write_ok_d = mem_write_ok_q;
      flush_d        = 1'b0;
      if (xfer) begin
         out_valid_d    = 1'b1;
         branch_taken_d = ~trap_hit & branch & cond_true;
         reg_write_ok_d = ~trap_hit & reg_write & cond_true;
         mem_write_ok_d = ~trap_hit & mem_write & cond_true;
         flush_d        = trap_hit | (branch & cond_true);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Branch statistics: clear wins over a same-cycle increment; trapping
   // branches are not counted.
   always_comb begin
      taken_cnt_d     = taken_cnt_q;
      not_taken_cnt_d = not_taken_cnt_q;
      if (cnt_clr) begin
         taken_cnt_d     = '0;
         not_taken_cnt_d = '0;
      end else if (xfer && branch && !trap_hit) begin
         if (cond_true) taken_cnt_d     = sat_inc(taken_cnt_q);
         else           not_taken_cnt_d = sat_inc(not_taken_cnt_q);
      end
   end

   // State, result and counter registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= RUN;
         out_valid_q     <= 1'b0;
         branch_taken_q  <= 1'b0;
         reg_write_ok_q  <= 1'b0;
         mem_write_ok_q  <= 1'b0;
         flush_q         <= 1'b0;
         taken_cnt_q     <= '0;
         not_taken_cnt_q <= '0;
      end else begin
         state_q         <= state_d;
         out_valid_q     <= out_valid_d;
         branch_taken_q  <= branch_taken_d;
         reg_write_ok_q  <= reg_write_ok_d;
         mem_write_ok_q  <= mem_write_ok_d;
         flush_q         <= flush_d;
         taken_cnt_q     <= taken_cnt_d;
         not_taken_cnt_q <= not_taken_cnt_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign branch_taken  = branch_taken_q;
   assign reg_write_ok  = reg_write_ok_q;
   assign mem_write_ok  = mem_write_ok_q;
   assign flush         = flush_q;
   assign trap          = (state_q == TRAP);
   assign taken_cnt     = taken_cnt_q;
   assign not_taken_cnt = not_taken_cnt_q;

endmodule

// File: tb/tb_cond_resolve_stage.sv
// Directed testbench for cond_resolve_stage (DATA_W=8, CNT_W=2).
module tb_cond_resolve_stage;

   localparam int DW = 8;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [DW-1:0] op_a, op_b;
   logic [3:0]    cond;
   logic          branch, reg_write, mem_write, alu_ovf, ovf_trap_en;
   logic          out_valid, out_ready;
   logic          branch_taken, reg_write_ok, mem_write_ok, flush, trap;
   logic          trap_ack, cnt_clr;
   logic [CW-1:0] taken_cnt, not_taken_cnt;

   int checks   = 0;
   int failures = 0;

   // Observed status vector: {out_valid, branch_taken, reg_write_ok, mem_write_ok, flush, trap, in_ready}
   logic [6:0] st;
   assign st = {out_valid, branch_taken, reg_write_ok, mem_write_ok, flush, trap, in_ready};

   always #5 clk = ~clk;

   cond_resolve_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .cond(cond),
      .branch(branch), .reg_write(reg_write), .mem_write(mem_write),
      .alu_ovf(alu_ovf), .ovf_trap_en(ovf_trap_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .branch_taken(branch_taken), .reg_write_ok(reg_write_ok), .mem_write_ok(mem_write_ok),
      .flush(flush), .trap(trap), .trap_ack(trap_ack), .cnt_clr(cnt_clr),
      .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
   );

   task automatic idle();
      in_valid = 0; op_a = '0; op_b = '0; cond = 4'd0; branch = 0; reg_write = 0;
      mem_write = 0; alu_ovf = 0; ovf_trap_en = 0; out_ready = 1; trap_ack = 0; cnt_clr = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      tick(); tick();
      checks++;
      if (st !== 7'b0000001) begin failures++; $display("FAIL reset_status got=%b exp=%b", st, 7'b0000001); end
      rst_n = 1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++;
      if ({taken_cnt, not_taken_cnt} !== 4'b0000) begin failures++; $display("FAIL reset_cnt got=%b exp=0000", {taken_cnt, not_taken_cnt}); end
   endtask

   task automatic test_signed_unsigned();
      op_a = 8'hF0; op_b = 8'h10; branch = 1; in_valid = 1; cond = 4'd5;
      tick();
      cond = 4'd10;
      checks++;
      if (st !== 7'b1100101) begin failures++; $display("FAIL lt_taken got=%b exp=%b", st, 7'b1100101); end
      checks++;
      if (taken_cnt !== 2'd1) begin failures++; $display("FAIL lt_taken_cnt got=%0d exp=1", taken_cnt); end
      tick();
      in_valid = 0;
      checks++;
      if (st !== 7'b1000001) begin failures++; $display("FAIL ltu_not_taken got=%b exp=%b", st, 7'b1000001); end
      checks++;
      if (not_taken_cnt !== 2'd1) begin failures++; $display("FAIL ltu_nt_cnt got=%0d exp=1", not_taken_cnt); end
      tick();
      checks++;
      if (st !== 7'b0000001) begin failures++; $display("FAIL drain got=%b exp=%b", st, 7'b0000001); end
      idle();
   endtask

   task automatic test_qualify();
      logic [15:0] expv;
      // a=-16/240, b=16: bit i is cond i's truth
      expv = 16'b0000_0011_1110_0101;
      op_a = 8'h05; op_b = 8'h05; cond = 4'd1; reg_write = 1; mem_write = 1; in_valid = 1;
      tick();
      cond = 4'd13;
      checks++;
      if (st !== 7'b1011001) begin failures++; $display("FAIL eq_writes got=%b exp=%b", st, 7'b1011001); end
      tick();
      checks++;
      if (st !== 7'b1000001) begin failures++; $display("FAIL reserved13 got=%b exp=%b", st, 7'b1000001); end
      // back-to-back sweep of all codes, one result per cycle
      op_a = 8'hF0; op_b = 8'h10; mem_write = 0;
      for (int i = 0; i < 16; i++) begin
         cond = 4'(i);
         tick();
         checks++;
         if ({out_valid, reg_write_ok, in_ready} !== {1'b1, expv[i], 1'b1})
            begin failures++; $display("FAIL sweep_cond%0d got=%b exp=%b", i, {out_valid, reg_write_ok, in_ready}, {1'b1, expv[i], 1'b1}); end
      end
      // sign boundary: 127 vs -128
      op_a = 8'h7F; op_b = 8'h80; cond = 4'd3;
      tick();
      cond = 4'd8;
      checks++;
      if (reg_write_ok !== 1'b1) begin failures++; $display("FAIL gt_7f_80 got=%b exp=1", reg_write_ok); end
      tick();
      checks++;
      if (reg_write_ok !== 1'b0) begin failures++; $display("FAIL gtu_7f_80 got=%b exp=0", reg_write_ok); end
      idle();
      tick();
   endtask

   task automatic test_trap();
      branch = 1; cond = 4'd7; alu_ovf = 1; ovf_trap_en = 1; reg_write = 1; mem_write = 1; in_valid = 1;
      tick();
      checks++;
      if (st !== 7'b1000110) begin failures++; $display("FAIL trap_enter got=%b exp=%b", st, 7'b1000110); end
      alu_ovf = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (st !== 7'b0000010) begin failures++; $display("FAIL trap_hold%0d got=%b exp=%b", i, st, 7'b0000010); end
      end
      trap_ack = 1; in_valid = 0;
      tick();
      trap_ack = 0;
      checks++;
      if (st !== 7'b0000001) begin failures++; $display("FAIL trap_exit got=%b exp=%b", st, 7'b0000001); end
      checks++;
      if ({taken_cnt, not_taken_cnt} !== {2'd1, 2'd1}) begin failures++; $display("FAIL trap_cnt got=%b exp=%b", {taken_cnt, not_taken_cnt}, {2'd1, 2'd1}); end
      idle();
   endtask

   task automatic test_stall_back_to_back();
      op_a = 8'h03; op_b = 8'h03; cond = 4'd1; branch = 1; out_ready = 0; in_valid = 1;
      tick();
      cond = 4'd12;
      checks++;
      if (st !== 7'b1100100) begin failures++; $display("FAIL stall0 got=%b exp=%b", st, 7'b1100100); end
      for (int i = 1; i < 3; i++) begin
         tick();
         checks++;
         if (st !== 7'b1100000) begin failures++; $display("FAIL stall%0d got=%b exp=%b", i, st, 7'b1100000); end
      end
      checks++;
      if (taken_cnt !== 2'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=2", taken_cnt); end
      out_ready = 1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 0;
      checks++;
      if (st !== 7'b1000001) begin failures++; $display("FAIL after_stall got=%b exp=%b", st, 7'b1000001); end
      checks++;
      if (not_taken_cnt !== 2'd2) begin failures++; $display("FAIL after_stall_nt got=%0d exp=2", not_taken_cnt); end
      idle();
      tick();
   endtask

   task automatic test_saturate();
      logic [1:0] expc;
      cnt_clr = 1;
      tick();
      cnt_clr = 0;
      checks++;
      if ({taken_cnt, not_taken_cnt} !== 4'b0000) begin failures++; $display("FAIL cnt_clr got=%b exp=0000", {taken_cnt, not_taken_cnt}); end
      branch = 1; cond = 4'd7; in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         expc = (i >= 2) ? 2'd3 : 2'(i + 1);
         checks++;
         if ({taken_cnt, branch_taken, flush} !== {expc, 2'b11})
            begin failures++; $display("FAIL sat%0d got=%b exp=%b", i, {taken_cnt, branch_taken, flush}, {expc, 2'b11}); end
      end
      cnt_clr = 1;
      tick();
      cnt_clr = 0; in_valid = 0;
      checks++;
      if ({taken_cnt, branch_taken} !== 3'b001) begin failures++; $display("FAIL clr_priority got=%b exp=001", {taken_cnt, branch_taken}); end
      idle();
      tick();
   endtask

   task automatic test_async_reset();
      branch = 1; cond = 4'd7; alu_ovf = 1; ovf_trap_en = 1; out_ready = 0; in_valid = 1;
      tick();
      in_valid = 0;
      checks++;
      if (st !== 7'b1000110) begin failures++; $display("FAIL pre_areset got=%b exp=%b", st, 7'b1000110); end
      #2 rst_n = 0;
      #1;
      checks++;
      if (st[6:1] !== 6'b000000) begin failures++; $display("FAIL areset_async got=%b exp=000000", st[6:1]); end
      idle();
      #3 rst_n = 1;
      tick();
      checks++;
      if (st !== 7'b0000001) begin failures++; $display("FAIL areset_release got=%b exp=%b", st, 7'b0000001); end
      // trap_ack in RUN is ignored and a normal request still goes through
      trap_ack = 1; in_valid = 1; branch = 1; cond = 4'd0;
      tick();
      idle();
      checks++;
      if ({out_valid, branch_taken, trap, taken_cnt} !== {3'b110, 2'd1})
         begin failures++; $display("FAIL run_ack_ignored got=%b exp=%b", {out_valid, branch_taken, trap, taken_cnt}, {3'b110, 2'd1}); end
   endtask

   initial begin
      test_reset();
      test_signed_unsigned();
      test_qualify();
      test_trap();
      test_stall_back_to_back();
      test_saturate();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
